// File: rtl/soup_wb_io_bridge_if.sv
// Wishbone classic bus bundle between the management SoC master and the
// soup I/O bridge responder.
//   wbs_cyc_i  bus cycle valid           wbs_stb_i  strobe
//   wbs_we_i   1 = write                 wbs_sel_i  byte lane enables
//   wbs_adr_i  byte address              wbs_dat_i  write data
//   wbs_dat_o  read data (valid w/ ack)  wbs_ack_o  transfer acknowledge
// Signal names keep the responder-side suffixes used on the SoC harness.
interface soup_wb_io_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/soup_wb_io_bridge.sv
// Wishbone classic responder giving firmware access to the game I/O pins.
// Registers (word offsets from BASE_ADDR):
//   0x0 IN     synchronized pin levels (read-only)
//   0x4 EDGE   sticky rising-edge flags, write-1-to-clear (set beats clear)
//   0x8 OUT    output pin values, byte lanes 0/1 honoured
//   0xC OEB    output enables (active-low), byte lanes 0/1 honoured
//   0x10 IRQ_EN  edge interrupt mask (only with SOUP_WB_IRQ_EN defined)
// Ports:
//   wb_clk_i / wb_rst_i  clock, async active-high reset
//   wbs                  Wishbone slave modport
//   pin_in               raw asynchronous input pins
//   pin_out / pin_oeb    output pin values / active-low enables
//   irq                  registered |(EDGE & IRQ_EN), only with SOUP_WB_IRQ_EN
// Optional feature macro: SOUP_WB_IRQ_EN.
module soup_wb_io_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned N_IN      = 9,
  parameter int unsigned N_OUT     = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  soup_wb_io_bridge_if.slave   wbs,
  input  logic [N_IN-1:0]      pin_in,
  output logic [N_OUT-1:0]     pin_out,
  output logic [N_OUT-1:0]     pin_oeb
`ifdef SOUP_WB_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic [N_IN-1:0]  s1_q, s2_q, s3_q;
  logic [N_IN-1:0]  edge_q, edge_d, edge_clr;
  logic [N_OUT-1:0] out_q, out_d, oeb_q, oeb_d, wmask;
  logic [31:0]      lane_mask, rdata, dat_q, dat_d;
  logic             ack_q, ack_d;
  logic             selected, accept, wr;
  logic [2:0]       reg_idx;

`ifdef SOUP_WB_IRQ_EN
  logic [N_IN-1:0]  irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  assign selected = (wbs.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign reg_idx  = wbs.wbs_adr_i[4:2];
`else
  // 0x10 lies outside the 16-byte window here, so it is never selected.
  assign selected = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_idx  = {1'b0, wbs.wbs_adr_i[3:2]};
`endif

  logic unused_bits;
  assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:2]};

  // The ~ack guard makes held strobes ack every other cycle.
  assign accept = wbs.wbs_cyc_i & wbs.wbs_stb_i & selected & ~ack_q;
  assign wr     = accept & wbs.wbs_we_i;

  // Only byte lanes 0 and 1 carry OUT/OEB bits.
  assign lane_mask = {16'h0, {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
  assign wmask     = lane_mask[N_OUT-1:0];

  always_comb begin
    rdata = '0;
    case (reg_idx)
      3'd0: rdata[N_IN-1:0]  = s2_q;
      3'd1: rdata[N_IN-1:0]  = edge_q;
      3'd2: rdata[N_OUT-1:0] = out_q;
      3'd3: rdata[N_OUT-1:0] = oeb_q;
`ifdef SOUP_WB_IRQ_EN
      3'd4: rdata[N_IN-1:0]  = irq_en_q;
`endif
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = accept;
    dat_d    = (accept && !wbs.wbs_we_i) ? rdata : '0;
    edge_clr = (wr && reg_idx == 3'd1) ? wbs.wbs_dat_i[N_IN-1:0] : '0;
    // Rising edge is ORed in after the clear so a coincident set survives.
    edge_d   = (edge_q & ~edge_clr) | (s2_q & ~s3_q);
    out_d    = out_q;
    oeb_d    = oeb_q;
    if (wr && reg_idx == 3'd2) out_d = (out_q & ~wmask) | (wbs.wbs_dat_i[N_OUT-1:0] & wmask);
    if (wr && reg_idx == 3'd3) oeb_d = (oeb_q & ~wmask) | (wbs.wbs_dat_i[N_OUT-1:0] & wmask);
  end

`ifdef SOUP_WB_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr && reg_idx == 3'd4) irq_en_d = wbs.wbs_dat_i[N_IN-1:0];
    irq_d = |(edge_q & irq_en_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      edge_q <= '0;
      out_q  <= '0;
      oeb_q  <= '1;
      ack_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      s1_q   <= pin_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= edge_d;
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign pin_out       = out_q;
  assign pin_oeb       = oeb_q;

endmodule

// File: tb/tb_soup_wb_io_bridge.sv
// Directed self-checking bench for soup_wb_io_bridge. Define SOUP_WB_IRQ_EN
// to exercise the interrupt build.
module tb_soup_wb_io_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  pin_in;
  logic [15:0] pin_out, pin_oeb;
`ifdef SOUP_WB_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  soup_wb_io_bridge_if bus ();

  soup_wb_io_bridge #(
    .BASE_ADDR (BASE),
    .N_IN      (9),
    .N_OUT     (16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .pin_oeb  (pin_oeb)
`ifdef SOUP_WB_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after a rising edge; returns 1 ns after the cycle following ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    lat   = -1;
    rdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.wbs_ack_o) begin
        lat   = i;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    bus_idle();
    tick();
    check("dat_o back to 0 after ack", bus.wbs_dat_o, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] d;
    int          lat;
    wb_xfer(1'b1, BASE + off, dat, sel, d, lat);
    check({tag, " ack latency"}, 32'(lat), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    int          lat;
    wb_xfer(1'b0, BASE + off, 32'h0, 4'hF, d, lat);
    check({tag, " ack latency"}, 32'(lat), 32'd1);
    check(tag, d, exp);
  endtask

  // Holds a strobe for n cycles and returns how many acks were seen.
  task automatic hold_stb(input logic [31:0] adr, input int n, output int acks);
    acks = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.wbs_ack_o || bus.wbs_dat_o != 32'h0) acks++;
    end
    bus_idle();
    tick();
  endtask

  initial begin
    int acks;
    int seen;
    rst    = 1'b1;
    pin_in = 9'h0;
    bus_idle();
    tick();
    check("reset ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("reset dat_o", bus.wbs_dat_o, 32'h0);
    check("reset pin_out", {16'h0, pin_out}, 32'h0);
    check("reset pin_oeb", {16'h0, pin_oeb}, 32'h0000_FFFF);
    rst = 1'b0;
    tick();

    rd("read OEB after reset", 32'hC, 32'h0000_FFFF);

    wr("write OUT lanes 0-1", 32'h8, 32'h1234_A5C3, 4'b0011);
    check("pin_out after write", {16'h0, pin_out}, 32'h0000_A5C3);
    rd("readback OUT", 32'h8, 32'h0000_A5C3);
    wr("write OUT lane 0", 32'h8, 32'hFFFF_0000, 4'b0001);
    check("pin_out lane 0 only", {16'h0, pin_out}, 32'h0000_A500);
    rd("readback OUT lane 0", 32'h8, 32'h0000_A500);

    // Input synchronizer: a read accepted on the 2nd edge still sees the old level.
    pin_in = 9'h101;
    tick();
    rd("IN before sync settles", 32'h0, 32'h0);
    rd("IN after sync", 32'h0, 32'h0000_0101);
    rd("EDGE after rise", 32'h4, 32'h0000_0101);
    wr("EDGE W1C bit 0", 32'h4, 32'h0000_0001, 4'hF);
    rd("EDGE after W1C", 32'h4, 32'h0000_0100);
    wr("IN write ignored", 32'h0, 32'h0000_0000, 4'hF);
    rd("IN unchanged by write", 32'h0, 32'h0000_0101);

    // Set/clear collision on EDGE[3].
    pin_in = 9'h109;
    repeat (4) tick();
    rd("EDGE bit 3 set", 32'h4, 32'h0000_0108);
    pin_in = 9'h101;
    repeat (4) tick();
    pin_in = 9'h109;
    tick();
    tick();
    wr("W1C colliding with rise", 32'h4, 32'h0000_0008, 4'hF);
    rd("EDGE set wins", 32'h4, 32'h0000_0108);
    wr("W1C without rise", 32'h4, 32'h0000_0008, 4'hF);
    rd("EDGE bit 3 cleared", 32'h4, 32'h0000_0100);

    hold_stb(BASE + 32'h20, 4, acks);
    check("no ack outside window", 32'(acks), 32'd0);
`ifndef SOUP_WB_IRQ_EN
    hold_stb(BASE + 32'h10, 4, acks);
    check("no ack at 0x10", 32'(acks), 32'd0);
`endif

    // Continuous strobe: acks alternate.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE;
    check("held stb ack c0", {31'h0, bus.wbs_ack_o}, 32'h0);
    tick();
    check("held stb ack c1", {31'h0, bus.wbs_ack_o}, 32'h1);
    tick();
    check("held stb ack c2", {31'h0, bus.wbs_ack_o}, 32'h0);
    tick();
    check("held stb ack c3", {31'h0, bus.wbs_ack_o}, 32'h1);
    bus_idle();
    tick();

    // Reset while ack is high.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE + 32'hC;
    bus.wbs_dat_i = 32'h0;
    tick();
    check("ack before reset", {31'h0, bus.wbs_ack_o}, 32'h1);
    check("pin_oeb written 0", {16'h0, pin_oeb}, 32'h0);
    bus_idle();
    #1 rst = 1'b1;
    #1;
    check("ack cleared by async reset", {31'h0, bus.wbs_ack_o}, 32'h0);
    check("pin_oeb after async reset", {16'h0, pin_oeb}, 32'h0000_FFFF);
    check("pin_out after async reset", {16'h0, pin_out}, 32'h0);
    #1 rst = 1'b0;
    tick();

`ifdef SOUP_WB_IRQ_EN
    wr("write IRQ_EN", 32'h10, 32'h0000_0004, 4'hF);
    rd("readback IRQ_EN", 32'h10, 32'h0000_0004);
    repeat (3) tick();
    wr("clear all EDGE", 32'h4, 32'h0000_01FF, 4'hF);
    check("irq low before rise", {31'h0, irq}, 32'h0);
    pin_in = 9'h105;
    seen = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (irq && seen == 0) seen = i;
    end
    check("irq within 4 cycles", 32'((seen >= 1) && (seen <= 4)), 32'd1);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = BASE + 32'h4;
    bus.wbs_dat_i = 32'h0000_0004;
    tick();
    check("irq still high on clear ack", {31'h0, irq}, 32'h1);
    bus_idle();
    tick();
    check("irq low one cycle after clear", {31'h0, irq}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/soup_wb_io_bridge.md
Name: soup_wb_io_bridge

Overview:
- Wishbone classic responder, sits between the management SoC's wbs_* bus and the chip's user I/O pins.
- Lets firmware read the 9 game input pins (io_in[13:5]): synchronized levels plus sticky rising-edge flags.
- Lets firmware drive the 16 output pins (io_out[29:14]) and their output-enable lines (io_oeb[29:14]).
- Complements the pin-facing game logic. Firmware can override or observe the pins for bring-up and test.

Parameters:
BASE_ADDR, 32'h3000_0000, bus address of register 0; bits [3:0] ignored.
N_IN, 9, number of input pins sampled.
N_OUT, 16, number of output pins driven.

Ports:
wb_clk_i  input  1  clock, rising edge.
wb_rst_i  input  1  reset, asynchronous, active-high.
wbs_cyc_i  input  1  bus cycle valid.
wbs_stb_i  input  1  strobe.
wbs_we_i  input  1  1 = write.
wbs_sel_i  input  4  byte lane enables.
wbs_adr_i  input  32  byte address.
wbs_dat_i  input  32  write data.
wbs_dat_o  output  32  read data, valid while wbs_ack_o = 1.
wbs_ack_o  output  1  transfer acknowledge.
pin_in  input  N_IN  raw asynchronous pin levels (io_in[13:5]).
pin_out  output  N_OUT  output pin values (io_out[29:14]).
pin_oeb  output  N_OUT  output enables, active-low (io_oeb[29:14]).
irq  output  1  edge interrupt; present only with the optional feature.

Behaviour:
- Clocking and reset:
  - Single clock wb_clk_i.
  - wb_rst_i is asynchronous and active-high.
  - Reset values: wbs_ack_o = 0, wbs_dat_o = 0, pin_out = 0, pin_oeb = all 1s (pins tri-stated), EDGE = 0, synchronizer flops = 0, IRQ_EN = 0, irq = 0.
- Input path:
  - pin_in passes through a 2-flop synchronizer (s1, s2), then a previous-value flop (s3).
  - IN register = s2. A pin change appears in IN 2 clocks after the first sampling edge.
  - A rising edge is detected as s2 & ~s3. It sets the matching EDGE bit, which stays set (sticky).
- Register map (word offsets from BASE_ADDR; unused upper bits read 0):
  - 0x0 IN: read-only, bits [N_IN-1:0]; writes ignored.
  - 0x4 EDGE: write-1-to-clear. If a set and a clear hit the same bit in the same cycle, the set wins (bit stays 1).
  - 0x8 OUT: read/write, bits [N_OUT-1:0]. Byte lanes sel[0] and sel[1] are honoured; other lanes ignored.
  - 0xC OEB: read/write, same byte-lane rules as OUT.
- Address decode:
  - The block is selected when adr[31:4] == BASE_ADDR[31:4].
  - If not selected, it never acks and wbs_dat_o stays 0.
- Handshake:
  - A request is accepted on a clock edge where cyc & stb & selected & ~wbs_ack_o.
  - wbs_ack_o is high for exactly one cycle following acceptance. Latency is 1 cycle.
  - wbs_dat_o is registered with the ack and returns to 0 the cycle after.
  - A write takes effect on the same edge that raises ack, so pin_out/pin_oeb change 1 cycle after acceptance.
  - The master holds stb until it sees ack.
  - Back-to-back strobes are acked every other cycle; the ~ack guard forces this.
  - Dropping cyc or stb before ack aborts the request: no ack and no register side effects beyond the accept edge.
- Reset asserted mid-transfer: ack and all registers clear immediately and asynchronously; the pending transfer is lost.
- wbs_adr_i[1:0] is ignored (word-aligned access).

Optional Feature:
- Macro SOUP_WB_IRQ_EN.
- When defined:
  - Adds the irq port and an IRQ_EN register at offset 0x10 (read/write, N_IN bits, reset 0).
  - The decode range widens to adr[31:5] == BASE_ADDR[31:5].
  - irq is registered: irq = |(EDGE & IRQ_EN), delayed 1 cycle.
- When undefined:
  - No irq port and no IRQ_EN register.
  - Offset 0x10 is not decoded (no ack).

Test Plan:
- Reset, then read 0xC → ack 1 cycle after strobe, data 0x0000FFFF; pin_oeb = 16'hFFFF, pin_out = 0.
- Write 0x8 = 0x1234_A5C3 with sel = 4'b0011 → pin_out = 16'hA5C3 one cycle after accept; readback 0x0000A5C3. Then write 0x8 = 0xFFFF_0000 with sel = 4'b0001 → pin_out = 16'hA500.
- Drive pin_in = 9'h101 → IN reads 9'h101 from cycle 2 onward; EDGE reads 9'h101. Write 0x4 = 0x001 → EDGE = 9'h100.
- Raise pin_in[3] on the same cycle as a W1C write of 0x008 to EDGE → EDGE[3] remains 1.
- Hold stb for 4 cycles at address BASE_ADDR + 0x20 (non-IRQ build) → no ack. Hold stb continuously at 0x0 → ack pattern 0,1,0,1.
- Assert wb_rst_i while ack is high after a write of 0xC = 0 → ack drops immediately; pin_oeb returns to 16'hFFFF. With SOUP_WB_IRQ_EN: IRQ_EN = 0x004, rising edge on pin_in[2] → irq = 1 within 4 cycles; clearing EDGE[2] → irq = 0 one cycle later.
